// File: rtl/vin_pkg.sv
// vin_pkg: shared state encoding and default sizing for the video-input source controller.
package vin_pkg;
  typedef enum logic [1:0] {INT_RUN, WAIT_EXT, EXT_RUN, RESTART_INT} vin_state_e;
  localparam int LOCK_FRAMES_DEF = 4;
  localparam int TIMEOUT_CYCLES_DEF = 2000000;
  localparam int LINE_W_DEF = 12;
  localparam int PIX_W = 8;
  localparam int FB_W = 8;
  function automatic int wd_width(input int timeout_cycles);
    return $clog2(timeout_cycles);
  endfunction
endpackage

// File: rtl/vin_sig_detect.sv
// vin_sig_detect: external vsync/hsync edge detection, per-frame line check, lock tracking and loss watchdog.
module vin_sig_detect
  import vin_pkg::*;
#(
  parameter int LOCK_FRAMES    = LOCK_FRAMES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int LINE_W         = LINE_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ext_vsync,
  input  logic ext_hsync,
  output logic vs_rise,
  output logic frame_valid,
  output logic frame_invalid,
  output logic timeout,
  output logic locked
);
  localparam int WD_W = wd_width(TIMEOUT_CYCLES);
  localparam int LK_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [LINE_W-1:0] LINE_MAX = '1;
  localparam logic [WD_W-1:0] WD_END = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LK_W-1:0] LK_MAX = LK_W'(LOCK_FRAMES);
  logic vs_q, hs_q, hs_rise, to_q, to_d, locked_q, locked_d;
  logic [LINE_W-1:0] line_q, line_d, last_lines_q, last_lines_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [LK_W-1:0] lock_q, lock_d;
  always_comb begin
    vs_rise = ext_vsync & ~vs_q;
    hs_rise = ext_hsync & ~hs_q;
    frame_valid = vs_rise & (line_q != '0) & (line_q != LINE_MAX) & (line_q == last_lines_q);
    frame_invalid = vs_rise & ~frame_valid;
    // a vsync rise in the expiry cycle suppresses the timeout; to_q keeps it to one pulse
    timeout = ~vs_rise & ~to_q & (wd_q == WD_END);
    to_d = vs_rise ? 1'b0 : (to_q | timeout);
    wd_d = vs_rise ? '0 : (wd_q != WD_END) ? wd_q + 1'b1 : wd_q;
    line_d = vs_rise ? '0 : (hs_rise && line_q != LINE_MAX) ? line_q + 1'b1 : line_q;
    last_lines_d = vs_rise ? line_q : timeout ? '0 : last_lines_q;
    lock_d = (frame_invalid | timeout) ? '0 : (frame_valid && lock_q != LK_MAX) ? lock_q + 1'b1 : lock_q;
    locked_d = lock_d == LK_MAX;
    locked = locked_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q <= 1'b0;
      hs_q <= 1'b0;
      to_q <= 1'b0;
      wd_q <= '0;
      line_q <= '0;
      last_lines_q <= '0;
      lock_q <= '0;
      locked_q <= 1'b0;
    end else begin
      vs_q <= ext_vsync;
      hs_q <= ext_hsync;
      to_q <= to_d;
      wd_q <= wd_d;
      line_q <= line_d;
      last_lines_q <= last_lines_d;
      lock_q <= lock_d;
      locked_q <= locked_d;
    end
  end
endmodule

// File: rtl/vin_src_ctrl.sv
// vin_src_ctrl: frame-aligned selection between external video and the internal pattern generator,
// with automatic fallback to the internal source on lost or unstable external signal.
module vin_src_ctrl
  import vin_pkg::*;
#(
  parameter int LOCK_FRAMES    = LOCK_FRAMES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int LINE_W         = LINE_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             force_int,
  input  logic             force_ext,
  input  logic             ext_vsync,
  input  logic             ext_hsync,
  input  logic             ext_de,
  input  logic [PIX_W-1:0] ext_pixel,
  input  logic             int_vsync,
  input  logic             int_hsync,
  input  logic             int_de,
  input  logic [PIX_W-1:0] int_pixel,
  output logic             int_rst,
  output logic             o_vsync,
  output logic             o_hsync,
  output logic             o_de,
  output logic [PIX_W-1:0] o_pixel,
  output logic             sel_ext,
  output logic             locked,
  output logic [FB_W-1:0]  fallback_cnt
);
  vin_state_e state_q, state_d;
  logic [PIX_W+2:0] out_q, out_d;
  logic sel_ext_q, sel_ext_d, int_rst_q, int_rst_d, vs_rise, frame_valid, frame_invalid, timeout, ext_bad;
  logic [FB_W-1:0] fb_q, fb_d;
  vin_sig_detect #(
    .LOCK_FRAMES(LOCK_FRAMES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .LINE_W(LINE_W)
  ) u_sd (
    .clk(clk),
    .rst(rst),
    .ext_vsync(ext_vsync),
    .ext_hsync(ext_hsync),
    .vs_rise(vs_rise),
    .frame_valid(frame_valid),
    .frame_invalid(frame_invalid),
    .timeout(timeout),
    .locked(locked)
  );
  always_comb begin
    ext_bad = ~force_ext & (timeout | frame_invalid);
    state_d = state_q;
    case (state_q)
      INT_RUN: state_d = ((locked | force_ext) & ~force_int) ? WAIT_EXT : INT_RUN;
      // a rise that is itself a bad frame only commits to external if lock still stands or is forced
      WAIT_EXT: state_d = force_int ? INT_RUN :
                          (vs_rise & (frame_valid | locked | force_ext)) ? EXT_RUN :
                          (~locked & ~force_ext) ? INT_RUN : WAIT_EXT;
      EXT_RUN: state_d = (force_int | ext_bad) ? RESTART_INT : EXT_RUN;
      default: state_d = INT_RUN;
    endcase
    out_d = (state_d == EXT_RUN) ? {ext_vsync, ext_hsync, ext_de, ext_pixel} :
            (state_d == INT_RUN) ? {int_vsync, int_hsync, int_de, int_pixel} : '0;
    sel_ext_d = state_d == EXT_RUN;
    int_rst_d = state_d == RESTART_INT;
    fb_d = (state_q == EXT_RUN && !force_int && ext_bad && fb_q != '1) ? fb_q + 1'b1 : fb_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INT_RUN;
      out_q <= '0;
      sel_ext_q <= 1'b0;
      int_rst_q <= 1'b1;
      fb_q <= '0;
    end else begin
      state_q <= state_d;
      out_q <= out_d;
      sel_ext_q <= sel_ext_d;
      int_rst_q <= int_rst_d;
      fb_q <= fb_d;
    end
  end
  assign {o_vsync, o_hsync, o_de, o_pixel} = out_q;
  assign sel_ext = sel_ext_q;
  assign int_rst = int_rst_q;
  assign fallback_cnt = fb_q;
endmodule

// File: tb/tb_vin_src_ctrl.sv
// tb_vin_src_ctrl: scoreboard bench; each driven cycle queues the expected registered output word.
module tb_vin_src_ctrl;
  localparam int SRC_INT = 0;
  localparam int SRC_EXT = 1;
  localparam int SRC_BLK = 2;
  logic clk = 0, rst = 1, force_int = 0, force_ext = 0;
  logic ext_vsync = 0, ext_hsync = 0, ext_de = 0, int_vsync = 0, int_hsync = 0, int_de = 0;
  logic [7:0] ext_pixel = 0, int_pixel = 0, o_pixel, fallback_cnt;
  logic int_rst, o_vsync, o_hsync, o_de, sel_ext, locked;
  logic [11:0] exp_q[$];
  int n_vec = 0, n_err = 0, fb_exp = 0;
  wire [11:0] got = {sel_ext, o_vsync, o_hsync, o_de, o_pixel};

  vin_src_ctrl #(.LOCK_FRAMES(2), .TIMEOUT_CYCLES(1000), .LINE_W(12)) dut (
    .clk(clk), .rst(rst), .force_int(force_int), .force_ext(force_ext),
    .ext_vsync(ext_vsync), .ext_hsync(ext_hsync), .ext_de(ext_de), .ext_pixel(ext_pixel),
    .int_vsync(int_vsync), .int_hsync(int_hsync), .int_de(int_de), .int_pixel(int_pixel),
    .int_rst(int_rst), .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de), .o_pixel(o_pixel),
    .sel_ext(sel_ext), .locked(locked), .fallback_cnt(fallback_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int src);
    {int_vsync, int_hsync, int_de} = 3'($urandom);
    int_pixel = 8'($urandom);
    ext_de = 1'($urandom);
    ext_pixel = 8'($urandom);
    exp_q.push_back(src == SRC_EXT ? {1'b1, ext_vsync, ext_hsync, ext_de, ext_pixel} :
                    src == SRC_INT ? {1'b0, int_vsync, int_hsync, int_de, int_pixel} : 12'h000);
    step();
  endtask

  task automatic idle(input int n, input int src, input string tag);
    logic [11:0] e;
    for (int i = 0; i < n; i++) begin
      ext_vsync = 0;
      ext_hsync = 0;
      drive(src);
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL %s cyc %0d: sel/o_* got %h want %h", tag, i, got, e);
      end
    end
  endtask

  // l lines (hsync pulses) then a single vsync-high cycle; pre covers line cycles, rise the vsync cycle
  task automatic frame(input int l, input int pre, input int rise, input string tag);
    logic [11:0] e;
    for (int c = 0; c <= 2 * l; c++) begin
      ext_vsync = (c == 2 * l);
      ext_hsync = (c < 2 * l) && (c % 2 == 0);
      drive(c == 2 * l ? rise : pre);
      e = exp_q.pop_front();
      n_vec++;
      if (got !== e) begin
        n_err++;
        $display("FAIL %s cyc %0d: sel/o_* got %h want %h", tag, c, got, e);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      {int_vsync, int_hsync, int_de} = 3'b111;
      int_pixel = 8'($urandom);
      step();
    end
    n_vec++;
    if (got !== 12'h000 || int_rst !== 1'b1 || locked !== 1'b0 || fallback_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_vals: out %h int_rst %b locked %b fb %0d want 000/1/0/0", got, int_rst, locked, fallback_cnt);
    end
    rst = 0;
    idle(1, SRC_INT, "rst_release");
    n_vec++;
    if (int_rst !== 1'b0) begin
      n_err++;
      $display("FAIL rst_release_int_rst: got %b want 0", int_rst);
    end
    idle(8, SRC_INT, "int_track");
  endtask

  task automatic test_lock();
    frame(10, SRC_INT, SRC_INT, "lock_f1");
    frame(10, SRC_INT, SRC_INT, "lock_f2");
    n_vec++;
    if (locked !== 1'b0) begin
      n_err++;
      $display("FAIL lock_early: locked got %b want 0", locked);
    end
    frame(10, SRC_INT, SRC_INT, "lock_f3");
    n_vec++;
    if (locked !== 1'b1) begin
      n_err++;
      $display("FAIL lock_f3_locked: got %b want 1", locked);
    end
    frame(10, SRC_BLK, SRC_EXT, "lock_f4");
    n_vec++;
    if (sel_ext !== 1'b1 || o_vsync !== 1'b1) begin
      n_err++;
      $display("FAIL lock_switch: sel_ext %b o_vsync %b want 1 1", sel_ext, o_vsync);
    end
    idle(1, SRC_EXT, "lock_ext");
  endtask

  task automatic test_mismatch();
    frame(9, SRC_EXT, SRC_BLK, "mism");
    fb_exp++;
    n_vec++;
    if (int_rst !== 1'b1 || fallback_cnt !== 8'(fb_exp) || locked !== 1'b0 || sel_ext !== 1'b0) begin
      n_err++;
      $display("FAIL mism_restart: int_rst %b fb %0d locked %b sel %b want 1 %0d 0 0", int_rst, fallback_cnt, locked, sel_ext, fb_exp);
    end
    idle(1, SRC_INT, "mism_int");
    n_vec++;
    if (int_rst !== 1'b0) begin
      n_err++;
      $display("FAIL mism_int_rst_pulse: got %b want 0", int_rst);
    end
  endtask

  task automatic test_signal_loss();
    force_ext = 1;
    idle(1, SRC_BLK, "loss_wait");
    frame(9, SRC_BLK, SRC_EXT, "loss_enter");
    idle(1100, SRC_EXT, "loss_forced");
    n_vec++;
    if (sel_ext !== 1'b1 || fallback_cnt !== 8'(fb_exp)) begin
      n_err++;
      $display("FAIL loss_forced_hold: sel %b fb %0d want 1 %0d", sel_ext, fallback_cnt, fb_exp);
    end
    frame(9, SRC_EXT, SRC_EXT, "loss_f1");
    frame(9, SRC_EXT, SRC_EXT, "loss_f2");
    force_ext = 0;
    idle(999, SRC_EXT, "loss_wdog");
    idle(1, SRC_BLK, "loss_timeout");
    fb_exp++;
    n_vec++;
    if (fallback_cnt !== 8'(fb_exp) || int_rst !== 1'b1) begin
      n_err++;
      $display("FAIL loss_fallback: fb %0d int_rst %b want %0d 1", fallback_cnt, int_rst, fb_exp);
    end
    idle(1, SRC_INT, "loss_int");
  endtask

  task automatic test_force();
    force_int = 1;
    force_ext = 1;
    idle(1, SRC_INT, "force_both");
    for (int k = 0; k < 3; k++) frame(9, SRC_INT, SRC_INT, "force_frames");
    n_vec++;
    if (locked !== 1'b1) begin
      n_err++;
      $display("FAIL force_locked: got %b want 1", locked);
    end
    idle(5, SRC_INT, "force_hold_int");
    n_vec++;
    if (fallback_cnt !== 8'(fb_exp)) begin
      n_err++;
      $display("FAIL force_fb: got %0d want %0d", fallback_cnt, fb_exp);
    end
    force_int = 0;
    idle(1500, SRC_BLK, "force_wait_blank");
    n_vec++;
    if (locked !== 1'b0) begin
      n_err++;
      $display("FAIL force_lock_lost: got %b want 0", locked);
    end
    force_ext = 0;
    idle(2, SRC_INT, "force_release");
  endtask

  task automatic test_line_sat();
    force_ext = 1;
    idle(1, SRC_BLK, "lsat_wait");
    frame(0, SRC_BLK, SRC_EXT, "lsat_enter");
    idle(1, SRC_EXT, "lsat_gap");
    frame(5000, SRC_EXT, SRC_EXT, "lsat_lines");
    n_vec++;
    if (dut.u_sd.last_lines_q !== 12'hfff || locked !== 1'b0) begin
      n_err++;
      $display("FAIL lsat_count: lines %0d locked %b want 4095 0", dut.u_sd.last_lines_q, locked);
    end
    idle(1, SRC_EXT, "lsat_gap2");
  endtask

  task automatic test_fb_sat();
    for (int k = 0; k < 300; k++) begin
      force_ext = 0;
      frame(0, SRC_EXT, SRC_BLK, "fbsat_drop");
      fb_exp = (fb_exp < 255) ? fb_exp + 1 : 255;
      n_vec++;
      if (fallback_cnt !== 8'(fb_exp) || int_rst !== 1'b1) begin
        n_err++;
        $display("FAIL fbsat_cnt iter %0d: fb %0d int_rst %b want %0d 1", k, fallback_cnt, int_rst, fb_exp);
      end
      idle(1, SRC_INT, "fbsat_int");
      force_ext = 1;
      idle(1, SRC_BLK, "fbsat_wait");
      frame(0, SRC_BLK, SRC_EXT, "fbsat_enter");
      idle(1, SRC_EXT, "fbsat_ext");
    end
    n_vec++;
    if (fallback_cnt !== 8'd255) begin
      n_err++;
      $display("FAIL fbsat_final: got %0d want 255", fallback_cnt);
    end
  endtask

  task automatic test_reset_mid();
    #2 rst = 1;
    #1;
    n_vec++;
    if (got !== 12'h000 || int_rst !== 1'b1 || fallback_cnt !== 8'd0 || locked !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: out %h int_rst %b fb %0d locked %b want 000 1 0 0", got, int_rst, fallback_cnt, locked);
    end
    force_ext = 0;
    step();
    rst = 0;
    idle(3, SRC_INT, "reset_mid_int");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_mismatch();
    test_signal_loss();
    test_force();
    test_line_sat();
    test_fb_sat();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vin_src_ctrl.md
Name: vin_src_ctrl

Overview:
- Video-input source controller sitting in front of the frame capture path.
- Selects between the external video input and the internal test-pattern generator (vin_internal), monitoring the external signal for lock.
- Switches sources only at frame boundaries and falls back to the internal source on signal loss.
- Drives the internal generator's reset, so the internal pattern always restarts from a clean frame start.

Parameters:
- LOCK_FRAMES, 4, consecutive valid external frames required to declare lock.
- TIMEOUT_CYCLES, 2000000, clk cycles without an external vsync rising edge before signal is declared lost.
- LINE_W, 12, width of the per-frame hsync (line) counter.

Ports:
- clk  in  1  pixel clock; all video inputs are synchronous to it.
- rst  in  1  reset; asynchronous, active-high.
- force_int  in  1  force internal source; has priority over force_ext.
- force_ext  in  1  force external source; ignores lock and timeout.
- ext_vsync, ext_hsync, ext_de  in  1 each  external timing, active-high.
- ext_pixel  in  8  external pixel.
- int_vsync, int_hsync, int_de  in  1 each  timing from vin_internal.
- int_pixel  in  8  pixel from vin_internal.
- int_rst  out  1  reset to vin_internal.
- o_vsync, o_hsync, o_de  out  1 each  selected timing, registered.
- o_pixel  out  8  selected pixel, registered.
- sel_ext  out  1  1 = external source on the outputs.
- locked  out  1  external lock status.
- fallback_cnt  out  8  saturating count of EXT->INT fallbacks.

Behaviour:
- Reset values:
  - state INT_RUN; all o_* 0; sel_ext 0; locked 0; fallback_cnt 0; int_rst 1.
  - int_rst deasserts on the first clk edge after rst falls.
- Edge detect: ext_vsync and ext_hsync are registered once; rise = cur & ~prev.
- Line counter:
  - Counts ext_hsync rises; cleared to 0 on ext_vsync rise, after its value is sampled into last_lines.
  - Saturates at all-ones.
- Valid frame: on ext_vsync rise, frame is valid iff line count != 0, != all-ones, and == last_lines.
  - The first frame after reset or timeout compares against last_lines = 0, so it is always invalid.
- Lock counter:
  - Valid frame: +1, saturating at LOCK_FRAMES.
  - Invalid frame or timeout: cleared to 0.
  - locked = (lock_cnt == LOCK_FRAMES), registered.
- Watchdog: counts clk cycles since the last ext_vsync rise. Reaching TIMEOUT_CYCLES-1 gives a 1-cycle timeout pulse, clears lock, and holds the counter until the next rise.
- All o_* are registered: 1-cycle latency from the selected source.
  - In blanking states, o_* = 0.
- State machine:
  - INT_RUN: outputs from int_*.
    - Go to WAIT_EXT if (locked | force_ext) & ~force_int.
  - WAIT_EXT: outputs blanked.
    - On ext_vsync rise: go to EXT_RUN; that same input cycle is muxed from ext, so o_vsync rises 1 cycle later.
    - Go to INT_RUN if force_int, or if locked drops while ~force_ext.
  - EXT_RUN: outputs from ext_*; sel_ext = 1.
    - Exit to RESTART_INT if force_int, or if (timeout | invalid frame) while ~force_ext.
  - RESTART_INT: outputs blanked; int_rst = 1 for exactly 1 cycle.
    - fallback_cnt +1 (saturating at 255) if entry was not caused by force_int.
    - Next cycle go to INT_RUN.
- sel_ext is registered with the outputs: 1 exactly while EXT_RUN outputs are driven.
- Simultaneous events:
  - force_int and force_ext: force_int wins.
  - Timeout and ext_vsync rise in the same cycle: the rise wins; the watchdog is cleared and the frame is evaluated normally.
- Reset mid-frame: immediate return to reset values; lock is re-acquired from 0.

Decomposition:
- Shared package vin_pkg holds:
  - state encoding (INT_RUN, WAIT_EXT, EXT_RUN, RESTART_INT);
  - localparam widths, with watchdog width = clog2(TIMEOUT_CYCLES).
- Sub-module vin_sig_detect holds the edge detectors, line counter, lock counter and watchdog.
  - Outputs: vs_rise, frame_valid, frame_invalid, timeout, locked.
- vin_src_ctrl holds the FSM, output mux/registers, int_rst and fallback_cnt.

Test Plan:
All scenarios use LOCK_FRAMES=2 and TIMEOUT_CYCLES=1000.
- Reset: hold rst 3 cycles -> all o_* 0, int_rst 1, sel_ext 0; first cycle after release int_rst 0 and o_* track int_* with 1-cycle delay.
- Lock acquisition: ext frames of 10 lines each -> lock on the 3rd vsync rise (the first frame compares against last_lines=0) -> WAIT_EXT blanks outputs; sel_ext=1 and o_vsync rise 1 cycle after the 4th ext vsync rise.
- Line mismatch in EXT_RUN: a frame of 9 lines -> at its vsync rise: RESTART_INT, int_rst pulses 1 cycle, fallback_cnt=1, locked=0, then INT_RUN.
- Signal loss: stop ext_vsync while in EXT_RUN -> fallback 1000 cycles after the last rise, fallback_cnt increments; with force_ext=1 the output stays on ext.
- Force priority: force_int=force_ext=1 while locked -> stays INT_RUN, fallback_cnt unchanged; force_int 1->0 with force_ext=1 and no ext signal -> WAIT_EXT blanked indefinitely.
- Saturation: 300 fallbacks -> fallback_cnt=255; 5000 ext hsyncs with LINE_W=12 and no vsync -> line count saturates at 4095, frame invalid.
